acc_pp2_seq: RTL and testbench

- Streaming accumulator that sits directly downstream of the convolution multipliers in pipeline_acc.
- Sums a variable-length group of signed products into one result.
- Every addition goes through the team's two-register-stage pipelined adder (latency 2).
- Two interleaved partial sums hide the adder latency, so a new term is accepted every cycle; the partials are folded into one result after the last term.

---
 rtl/acc_pp2_seq.sv | 76 +++++++
 tb/tb_acc_pp2_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/acc_pp2_seq.sv
// acc_pp2_seq: streaming signed accumulator with two interleaved partials over a latency-2 adder
module acc_pp2_seq #(
  parameter int C_DIN  = 16,
  parameter int C_DOUT = 32,
  parameter int C_CNT  = 12
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_clr,
  input  logic              I_din_valid,
  input  logic [C_DIN-1:0]  I_din,
  input  logic              I_din_last,
  output logic              O_din_ready,
  output logic              O_dout_valid,
  output logic [C_DOUT-1:0] O_dout,
  output logic [C_CNT-1:0]  O_beat_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_ACC, S_FOLD1, S_FOLD2, S_WAIT} state_t;
  state_t state_q, state_d;
  logic [C_DOUT-1:0] s1_q, s1_d, s2_q, fold_q, fold_d, dout_q, dout_d, a_op, b_op;
  logic [C_CNT-1:0] cnt_q, cnt_d, beat_q, beat_d;
  logic v1_q, v1_d, v2_q, dv_q, done, acc, accumulating;
  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (I_clr) state_d = S_IDLE;
    else if (state_q == S_IDLE || state_q == S_ACC) state_d = acc ? (I_din_last ? S_FOLD1 : S_ACC) : state_q;
    else if (state_q == S_FOLD1) state_d = S_FOLD2;
    else if (state_q == S_FOLD2) state_d = S_WAIT;
    else state_d = v2_q ? S_IDLE : S_WAIT;
  end
  always_comb begin
    accumulating = state_q == S_IDLE || state_q == S_ACC;
    O_din_ready  = accumulating;
    O_dout_valid = dv_q;
    O_dout       = dout_q;
    O_beat_cnt   = beat_q;
  end
  // fb from two cycles ago feeds back as b, so even and odd cycles carry separate partials
  always_comb begin
    acc     = I_din_valid & O_din_ready & ~I_clr;
    a_op    = acc ? {{(C_DOUT-C_DIN){I_din[C_DIN-1]}}, I_din} : '0;
    b_op    = v2_q ? s2_q : '0;
    s1_d    = (state_q == S_FOLD2 ? fold_q : a_op) + b_op;
    v1_d    = ~I_clr & (state_q == S_FOLD2 | (accumulating & (acc | v2_q)));
    fold_d  = I_clr ? '0 : state_q == S_FOLD1 ? b_op : fold_q;
    cnt_d   = I_clr ? '0 : !acc ? cnt_q : state_q == S_IDLE ? C_CNT'(1) : &cnt_q ? cnt_q : cnt_q + 1'b1;
    done    = state_q == S_WAIT & v2_q & ~I_clr;
    dout_d  = done ? s2_q : dout_q;
    beat_d  = done ? cnt_q : beat_q;
  end
  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      fold_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      beat_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s1_q;
      v1_q   <= v1_d;
      v2_q   <= ~I_clr & v1_q;
      fold_q <= fold_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      beat_q <= beat_d;
      dv_q   <= done;
    end
endmodule

// File: tb/tb_acc_pp2_seq.sv
// tb_acc_pp2_seq: randomized scoreboard bench for acc_pp2_seq, 32-bit and 17-bit accumulator instances
module tb_acc_pp2_seq;
  logic clk = 1'b0, rst_n, clr, din_valid, din_last;
  logic [15:0] din;
  logic ready, dv, ready17, dv17;
  logic [31:0] dout;
  logic [16:0] dout17;
  logic [11:0] bcnt, bcnt17;
  int checks = 0, fails = 0;
  longint cyc = 0;
  typedef struct {logic [31:0] s32; logic [16:0] s17; int n; longint cyc;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int terms[$];
  logic [31:0] last_s32 = '0;

  acc_pp2_seq u_dut (.I_clk(clk), .I_rst_n(rst_n), .I_clr(clr), .I_din_valid(din_valid), .I_din(din),
    .I_din_last(din_last), .O_din_ready(ready), .O_dout_valid(dv), .O_dout(dout), .O_beat_cnt(bcnt));
  acc_pp2_seq #(.C_DIN(16), .C_DOUT(17), .C_CNT(12)) u_n17 (.I_clk(clk), .I_rst_n(rst_n), .I_clr(clr),
    .I_din_valid(din_valid), .I_din(din), .I_din_last(din_last), .O_din_ready(ready17), .O_dout_valid(dv17),
    .O_dout(dout17), .O_beat_cnt(bcnt17));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) cyc=%0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (rst_n === 1'b1 && (dv === 1'b1 || dv17 === 1'b1)) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("valid32", dv, 1);
        chk("valid17", dv17, 1);
        chk("dout32", dout, e.s32);
        chk("dout17", dout17, e.s17);
        chk("beat_cnt32", bcnt, e.n);
        chk("beat_cnt17", bcnt17, e.n);
      end
    end

  task automatic drive(input logic v, input logic [15:0] d, input logic l, input logic c);
    @(posedge clk);
    #1;
    din_valid = v; din = d; din_last = l; clr = c;
    if (v && !c) chk("ready_hi", ready, 1);
  endtask

  task automatic run_group(input int max_gap);
    logic [31:0] s32 = '0;
    logic [16:0] s17 = '0;
    logic [15:0] d;
    for (int i = 0; i < terms.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) drive(1'b0, 16'($urandom), 1'($urandom), 1'b0);
      d = 16'(terms[i]);
      drive(1'b1, d, i == terms.size() - 1, 1'b0);
      s32 = s32 + {{16{d[15]}}, d};
      s17 = s17 + {d[15], d};
    end
    exp_q.push_back('{s32: s32, s17: s17, n: terms.size(), cyc: cyc + 5});
    last_s32 = s32;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 16'($urandom), 1'($urandom), 1'b0);
      chk("ready_lo", ready, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; din_valid = 1'b0; din = '0; din_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_valid", dv, 0);
    chk("rst_dout", dout, 0);
    chk("rst_cnt", bcnt, 0);
    rst_n = 1'b1;
    terms = '{-5};
    run_group(0);
    terms = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_group(0);
    run_group(2);
    run_group(2);
    terms = '{100, -200, 50};
    run_group(0);
    terms = '{7};
    run_group(0);
    terms = '{32'h7fff, 32'h7fff};
    run_group(0);
    terms = '{-32768, -32768, -32768};
    run_group(1);
    for (int g = 0; g < 25; g++) begin
      terms = {};
      for (int i = 0; i < $urandom_range(1, 10); i++) terms.push_back(int'($urandom_range(0, 65535)));
      run_group($urandom_range(0, 3));
    end
    // abort a group after three beats; the beat alongside clr must be dropped
    drive(1'b1, 16'd11, 1'b0, 1'b0);
    drive(1'b1, 16'd22, 1'b0, 1'b0);
    drive(1'b1, 16'd33, 1'b0, 1'b0);
    drive(1'b1, 16'd77, 1'b1, 1'b1);
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    chk("clr_ready", ready, 1);
    chk("clr_dout_kept", dout, last_s32);
    repeat (6) drive(1'b0, 16'd0, 1'b0, 1'b0);
    terms = '{9};
    run_group(0);
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    // asynchronous reset while the group sits in FOLD2
    drive(1'b1, 16'd1, 1'b0, 1'b0);
    drive(1'b1, 16'd2, 1'b0, 1'b0);
    drive(1'b1, 16'd3, 1'b1, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    chk("fold2_ready", ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", ready, 1);
    chk("arst_dout", dout, 0);
    chk("arst_cnt", bcnt, 0);
    chk("arst_valid", dv, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) drive(1'b0, 16'd0, 1'b0, 1'b0);
    terms = '{-3, 4, -5, 6};
    run_group(1);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
